otter_fetch_queue: RTL and testbench
====================================

Name: otter_fetch_queue

Overview:
Instruction fetch stage for the pipelined OTTER. It owns the fetch PC, issues reads on instruction-memory port 1, and buffers returned instructions in a small prefetch FIFO. It presents instructions to the IF/DE pipeline register with a valid/ready handshake, so decode can stall without losing fetched words. It also accepts a one-cycle redirect from Execute on a taken branch or jump; the redirect flushes the queue and all in-flight fetches.

Parameters:
DEPTH, 4, queue entries; power of 2, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_IR, 32'h0000_0013, instruction presented when IF_VALID=0 (addi x0,x0,0)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-high reset
REDIRECT  in  1  Execute redirect strobe (taken branch/jal/jalr)
REDIRECT_PC  in  32  redirect target
DE_READY  in  1  decode accepts the head instruction this cycle
MEM_READ1  out  1  instruction read request (port 1)
MEM_ADDR1  out  32  instruction read address
MEM_DOUT1  in  32  instruction data, valid the cycle after MEM_READ1
IF_VALID  out  1  head entry valid
IF_IR  out  32  head instruction (NOP_IR when !IF_VALID)
IF_PC  out  32  head PC (0 when !IF_VALID)
Q_COUNT  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async, RESET=1): fetch_pc=RESET_PC; wr/rd pointers=0; count=0; pending=0. While RESET is high: MEM_READ1=0, IF_VALID=0, IF_IR=NOP_IR, IF_PC=0, Q_COUNT=0. Reset mid-operation drops all queue contents and in-flight reads immediately.
- State: fetch_pc, pending flag plus pending_pc (one outstanding read max), FIFO of {ir,pc} with wrap-around pointers mod DEPTH, count.
- Issue (combinational): MEM_READ1 = !RESET && !REDIRECT && (count + pending < DEPTH). MEM_ADDR1 = fetch_pc. The credit check ignores a same-cycle dequeue (conservative).
- On issue edge: pending<=1, pending_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^32; 0xFFFF_FFFC wraps to 0). With no issue, pending<=0.
- Return: when pending=1, MEM_DOUT1 is captured on that edge into FIFO[wr_ptr] as {MEM_DOUT1, pending_pc}; wr_ptr++.
- Output: IF_VALID = (count!=0) && !REDIRECT. IF_IR/IF_PC come from FIFO[rd_ptr] when IF_VALID, else NOP_IR/0. Outputs are registered-data reads, with no bypass from MEM_DOUT1.
- Dequeue: IF_VALID && DE_READY; rd_ptr++ on the edge. A simultaneous enqueue and dequeue leaves count unchanged.
- Latency: issue in cycle N, enqueue at end of N+1, IF_VALID in N+2. Steady state with DE_READY=1 delivers 1 instruction/cycle.
- Stall: with DE_READY=0, the queue fills to DEPTH, MEM_READ1 drops, and fetch_pc holds. The queue never overflows, because a pending return always has a reserved slot.
- Redirect (priority over issue, enqueue and dequeue): in the REDIRECT cycle, IF_VALID=0, MEM_READ1=0, and nothing is dequeued. On the edge: pointers=0, count=0, pending=0 (the in-flight return is discarded), fetch_pc<=REDIRECT_PC with bits[1:0] forced to 0.
- Redirect penalty: first target issue in R+1, IF_VALID with target in R+3.
- Back-to-back redirects: the later one wins; each flushes.
- Empty: IF_VALID=0, IF_IR=NOP_IR (bubble into decode).

Test Plan:
- Reset release, RESET_PC=0, DE_READY=1, memory word at addr = addr+0x100:
  - MEM_ADDR1 = 0,4,8… on consecutive cycles.
  - IF_VALID first high 2 cycles after first issue, with IF_PC=0, IF_IR=0x100.
  - Then one instruction per cycle with PCs 0,4,8,12.
- Stall: DE_READY=0 for 10 cycles after start:
  - Q_COUNT saturates at 4 and MEM_READ1=0.
  - Head holds PC 0.
  - On DE_READY=1, PCs 0..12 are delivered consecutively with no gap and no duplicate; PC 16 follows.
- Redirect with REDIRECT_PC=0x200 while queue holds 2 entries and 1 read is in flight:
  - IF_VALID=0 in cycle R.
  - Next MEM_ADDR1=0x200.
  - IF_VALID with IF_PC=0x200 at R+3.
  - No stale PC appears afterwards.
- Redirect asserted together with DE_READY=1 and a valid head: the head is not consumed. Unaligned REDIRECT_PC=0x203 -> fetch address 0x200.
- Asynchronous RESET pulse mid-cycle with a full queue:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - After release, fetching restarts at RESET_PC.
- Wrap: REDIRECT_PC=0xFFFF_FFF8 -> delivered PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. FIFO pointers wrap correctly across more than 3*DEPTH transfers.

Source files
------------

// File: rtl/otter_fetch_queue_if.sv
// Fetch-stage bundle: instruction-memory port 1, Execute redirect and the IF/DE handshake.
interface otter_fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  logic                    REDIRECT;
  logic [31:0]             REDIRECT_PC;
  logic                    DE_READY;
  logic                    MEM_READ1;
  logic [31:0]             MEM_ADDR1;
  logic [31:0]             MEM_DOUT1;
  logic                    IF_VALID;
  logic [31:0]             IF_IR;
  logic [31:0]             IF_PC;
  logic [$clog2(DEPTH):0]  Q_COUNT;

  // Fetch unit side
  modport master (
    input  REDIRECT, REDIRECT_PC, DE_READY, MEM_DOUT1,
    output MEM_READ1, MEM_ADDR1, IF_VALID, IF_IR, IF_PC, Q_COUNT
  );

  // Execute / memory / decode side
  modport slave (
    output REDIRECT, REDIRECT_PC, DE_READY, MEM_DOUT1,
    input  MEM_READ1, MEM_ADDR1, IF_VALID, IF_IR, IF_PC, Q_COUNT
  );
endinterface

// File: rtl/otter_fetch_queue.sv
// OTTER fetch stage: owns the fetch PC, keeps at most one read in flight and buffers
// returned words in a small {ir,pc} FIFO that decode drains with a valid/ready handshake.
module otter_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_IR   = 32'h0000_0013
) (
  input  logic                CLK,
  input  logic                RESET,
  otter_fetch_queue_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

  logic [31:0]   fetch_pc_r;
  logic [31:0]   pending_pc_r;
  logic          pending_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [31:0]   ir_mem_r [DEPTH];
  logic [31:0]   pc_mem_r [DEPTH];

  logic [CW:0]   credit_s;
  logic [31:0]   redirect_pc_s;
  logic          issue_s;
  logic          enq_s;
  logic          deq_s;
  logic          valid_s;

  // Credit counts the in-flight read so every return has a reserved slot.
  assign credit_s      = {1'b0, count_r} + {{CW{1'b0}}, pending_r};
  assign issue_s       = !RESET && !bus.REDIRECT && (credit_s < DEPTH_C);
  assign enq_s         = pending_r && !bus.REDIRECT;
  assign valid_s       = (count_r != {CW{1'b0}}) && !bus.REDIRECT;
  assign deq_s         = valid_s && bus.DE_READY;
  assign redirect_pc_s = bus.REDIRECT_PC & 32'hFFFF_FFFC;

  // Fetch PC, outstanding-read tracking and FIFO bookkeeping; redirect flushes everything.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fetch_pc_r   <= RESET_PC;
      pending_pc_r <= 32'h0000_0000;
      pending_r    <= 1'b0;
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      count_r      <= {CW{1'b0}};
    end else if (bus.REDIRECT) begin
      fetch_pc_r   <= redirect_pc_s;
      pending_r    <= 1'b0;
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      count_r      <= {CW{1'b0}};
    end else begin
      if (issue_s) begin
        pending_r    <= 1'b1;
        pending_pc_r <= fetch_pc_r;
        fetch_pc_r   <= fetch_pc_r + 32'd4;
      end else begin
        pending_r    <= 1'b0;
      end
      if (enq_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (deq_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until the pointers cover them.
  always_ff @(posedge CLK) begin
    if (enq_s) begin
      ir_mem_r[wr_ptr_r] <= bus.MEM_DOUT1;
      pc_mem_r[wr_ptr_r] <= pending_pc_r;
    end
  end

  // Head presentation: registered FIFO data only, bubble when empty or redirecting.
  always_comb begin
    bus.IF_IR = NOP_IR;
    bus.IF_PC = 32'h0000_0000;
    if (valid_s) begin
      bus.IF_IR = ir_mem_r[rd_ptr_r];
      bus.IF_PC = pc_mem_r[rd_ptr_r];
    end else begin
      bus.IF_IR = NOP_IR;
      bus.IF_PC = 32'h0000_0000;
    end
  end

  assign bus.MEM_READ1 = issue_s;
  assign bus.MEM_ADDR1 = fetch_pc_r;
  assign bus.IF_VALID  = valid_s;
  assign bus.Q_COUNT   = count_r;
endmodule

// File: tb/tb_otter_fetch_queue.sv
// Bench for otter_fetch_queue: memory returns addr+0x100, a scoreboard tracks issued reads
// and checks every head/dequeue, directed steps cover latency, stall, redirect, reset and wrap.
module tb_otter_fetch_queue;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  otter_fetch_queue_if #(.DEPTH(4)) bus ();

  otter_fetch_queue #(
    .DEPTH(4), .RESET_PC(32'h0000_0000), .NOP_IR(NOP)
  ) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } entry_t;

  entry_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_deliv = 0;

  // Memory responds one cycle after the request; garbage otherwise to expose bypasses.
  always @(posedge CLK)
    bus.MEM_DOUT1 <= bus.MEM_READ1 ? (bus.MEM_ADDR1 + 32'h0000_0100) : 32'hBAD0_BAD0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Scoreboard: push on issue, compare the head every cycle, pop on dequeue.
  always @(negedge CLK) begin
    if (RESET || bus.REDIRECT) begin
      sb.delete();
    end else begin
      if (bus.IF_VALID) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'(bus.IF_VALID), 32'd0);
        end else begin
          check("head_pc", bus.IF_PC, sb[0].pc);
          check("head_ir", bus.IF_IR, sb[0].ir);
          if (bus.DE_READY) begin
            void'(sb.pop_front());
            n_deliv++;
          end
        end
      end else begin
        check("bubble_ir", bus.IF_IR, NOP);
        check("bubble_pc", bus.IF_PC, 32'd0);
      end
      check("count_le_depth", 32'(bus.Q_COUNT > 3'd4), 32'd0);
      if (bus.MEM_READ1)
        sb.push_back('{pc: bus.MEM_ADDR1, ir: bus.MEM_ADDR1 + 32'h0000_0100});
    end
  end

  task automatic drive_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_read"},  32'(bus.MEM_READ1), 32'd0);
    check({tag, "_valid"}, 32'(bus.IF_VALID),  32'd0);
    check({tag, "_ir"},    bus.IF_IR,          NOP);
    check({tag, "_pc"},    bus.IF_PC,          32'd0);
    check({tag, "_count"}, 32'(bus.Q_COUNT),   32'd0);
  endtask

  task automatic do_reset(input logic de_ready);
    RESET           = 1'b1;
    bus.REDIRECT    = 1'b0;
    bus.REDIRECT_PC = 32'd0;
    bus.DE_READY    = de_ready;
    @(negedge CLK);
    @(negedge CLK);
    check_reset_outputs("rst");
    drive_edge();
    RESET = 1'b0;
  endtask

  initial begin
    int deliv_start;

    // Basic fetch and latency
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check("t1_addr",  bus.MEM_ADDR1, 32'(i * 4));
      check("t1_read",  32'(bus.MEM_READ1), 32'd1);
      check("t1_valid", 32'(bus.IF_VALID), (i >= 2) ? 32'd1 : 32'd0);
      if (i >= 2) check("t1_pc", bus.IF_PC, 32'((i - 2) * 4));
      if (i == 2) check("t1_ir", bus.IF_IR, 32'h0000_0100);
    end

    // Stall fills the queue, release drains with no gap
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) @(negedge CLK);
    check("t2_count", 32'(bus.Q_COUNT), 32'd4);
    check("t2_read",  32'(bus.MEM_READ1), 32'd0);
    check("t2_head",  bus.IF_PC, 32'd0);
    check("t2_hold",  bus.MEM_ADDR1, 32'd16);
    drive_edge();
    bus.DE_READY = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check("t2_valid", 32'(bus.IF_VALID), 32'd1);
      check("t2_pc",    bus.IF_PC, 32'(k * 4));
    end

    // Redirect with two queued entries and one read in flight
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) @(negedge CLK);
    drive_edge();
    bus.REDIRECT    = 1'b1;
    bus.REDIRECT_PC = 32'h0000_0200;
    @(negedge CLK);
    check("t3_qcnt",  32'(bus.Q_COUNT), 32'd2);
    check("t3_valid", 32'(bus.IF_VALID), 32'd0);
    check("t3_read",  32'(bus.MEM_READ1), 32'd0);
    drive_edge();
    bus.REDIRECT = 1'b0;
    bus.DE_READY = 1'b1;
    @(negedge CLK);
    check("t3_addr",  bus.MEM_ADDR1, 32'h0000_0200);
    check("t3_read1", 32'(bus.MEM_READ1), 32'd1);
    check("t3_flush", 32'(bus.Q_COUNT), 32'd0);
    @(negedge CLK);
    check("t3_r2",    32'(bus.IF_VALID), 32'd0);
    @(negedge CLK);
    check("t3_r3v",   32'(bus.IF_VALID), 32'd1);
    check("t3_r3pc",  bus.IF_PC, 32'h0000_0200);
    for (int i = 0; i < 4; i++) @(negedge CLK);

    // Unaligned redirect against a valid head with DE_READY high
    check("t4_pre", 32'(bus.IF_VALID), 32'd1);
    drive_edge();
    bus.REDIRECT    = 1'b1;
    bus.REDIRECT_PC = 32'h0000_0203;
    @(negedge CLK);
    check("t4_valid", 32'(bus.IF_VALID), 32'd0);
    check("t4_ir",    bus.IF_IR, NOP);
    drive_edge();
    bus.REDIRECT = 1'b0;
    @(negedge CLK);
    check("t4_addr", bus.MEM_ADDR1, 32'h0000_0200);
    @(negedge CLK);
    @(negedge CLK);
    check("t4_pc", bus.IF_PC, 32'h0000_0200);

    // Back-to-back redirects, later one wins, then PC wrap
    drive_edge();
    bus.REDIRECT    = 1'b1;
    bus.REDIRECT_PC = 32'h0000_1000;
    drive_edge();
    bus.REDIRECT_PC = 32'hFFFF_FFF8;
    drive_edge();
    bus.REDIRECT = 1'b0;
    @(negedge CLK);
    check("t5_addr", bus.MEM_ADDR1, 32'hFFFF_FFF8);
    @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("t5_valid", 32'(bus.IF_VALID), 32'd1);
      check("t5_pc",    bus.IF_PC, 32'hFFFF_FFF8 + 32'(k * 4));
    end

    // Random backpressure across many pointer wraps
    deliv_start = n_deliv;
    for (int i = 0; i < 60; i++) begin
      drive_edge();
      bus.DE_READY = 1'($urandom_range(0, 1));
    end
    check("t5_transfers", 32'(n_deliv - deliv_start >= 13), 32'd1);

    // Asynchronous reset pulse with a full queue
    drive_edge();
    bus.DE_READY = 1'b0;
    for (int i = 0; i < 8; i++) @(negedge CLK);
    check("t6_full", 32'(bus.Q_COUNT), 32'd4);
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    sb.delete();
    #1;
    RESET        = 1'b0;
    bus.DE_READY = 1'b1;
    @(negedge CLK);
    check("t6_addr", bus.MEM_ADDR1, 32'h0000_0000);
    check("t6_read", 32'(bus.MEM_READ1), 32'd1);
    @(negedge CLK);
    @(negedge CLK);
    check("t6_valid", 32'(bus.IF_VALID), 32'd1);
    check("t6_pc",    bus.IF_PC, 32'h0000_0000);
    for (int i = 0; i < 6; i++) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
